// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - round-robin two-requester burst arbiter for frame-buffer port A writes
// Grants whole bursts, registers accepted beats onto the port, flags out-of-range and stalled bursts.
module fb_write_arbiter #(
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 24,
  parameter int FB_DEPTH = 76800,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              map_req,
  input  logic [ADDR_W-1:0] map_addr,
  input  logic [DATA_W-1:0] map_data,
  input  logic              map_last,
  output logic              map_rdy,
  input  logic              spr_req,
  input  logic [ADDR_W-1:0] spr_addr,
  input  logic [DATA_W-1:0] spr_data,
  input  logic              spr_last,
  output logic              spr_rdy,
  input  logic              frame_lock,
  input  logic              clr_err,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              busy,
  output logic              oob_err,
  output logic              to_err
);

  typedef enum logic [1:0] {IDLE, GNT_MAP, GNT_SPR} state_t;

  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(FB_DEPTH);
  localparam logic [7:0]      TIMEOUT_C = 8'(TIMEOUT);

  state_t            state_q;
  logic              rr_spr_q;
  logic [7:0]        idle_cnt_q;
  logic [7:0]        idle_cnt_d;
  logic              gnt_map;
  logic              cur_req;
  logic              oth_req;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic              cur_last;
  logic              accept;
  logic              in_range;
  logic              timeout_hit;

  always_comb begin
    gnt_map     = (state_q == GNT_MAP);
    map_rdy     = gnt_map && map_req;
    spr_rdy     = (state_q == GNT_SPR) && spr_req;
    cur_req     = gnt_map ? map_req  : spr_req;
    oth_req     = gnt_map ? spr_req  : map_req;
    cur_addr    = gnt_map ? map_addr : spr_addr;
    cur_data    = gnt_map ? map_data : spr_data;
    cur_last    = gnt_map ? map_last : spr_last;
    accept      = map_rdy | spr_rdy;
    in_range    = {1'b0, cur_addr} < DEPTH_C;
    idle_cnt_d  = idle_cnt_q + 8'd1;
    timeout_hit = (state_q != IDLE) && !cur_req && (idle_cnt_d == TIMEOUT_C);
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_spr_q   <= 1'b0;
      idle_cnt_q <= '0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      oob_err    <= 1'b0;
      to_err     <= 1'b0;
    end else begin
      fb_we <= 1'b0;
      if (accept && in_range) begin
        fb_we   <= 1'b1;
        fb_addr <= cur_addr;
        fb_data <= cur_data;
      end

      // Set has priority over clear so an error in the clearing cycle is not lost.
      if (accept && !in_range) oob_err <= 1'b1;
      else if (clr_err)        oob_err <= 1'b0;
      if (timeout_hit)         to_err  <= 1'b1;
      else if (clr_err)        to_err  <= 1'b0;

      case (state_q)
        IDLE: begin
          idle_cnt_q <= '0;
          if (!frame_lock) begin
            if (map_req && (!spr_req || !rr_spr_q)) state_q <= GNT_MAP;
            else if (spr_req)                        state_q <= GNT_SPR;
          end
        end
        default: begin
          if (accept) begin
            idle_cnt_q <= '0;
            if (cur_last) begin
              rr_spr_q <= gnt_map;
              if (oth_req && !frame_lock) state_q <= gnt_map ? GNT_SPR : GNT_MAP;
              else                        state_q <= IDLE;
            end
          end else if (timeout_hit) begin
            idle_cnt_q <= '0;
            rr_spr_q   <= gnt_map;
            state_q    <= IDLE;
          end else begin
            idle_cnt_q <= idle_cnt_d;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb/tb_fb_write_arbiter.sv - directed and random checks of fb_write_arbiter against a cycle model
module tb_fb_write_arbiter;

  localparam int ADDR_W   = 17;
  localparam int DATA_W   = 24;
  localparam int FB_DEPTH = 76800;
  localparam int TIMEOUT  = 255;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              map_req, spr_req, map_last, spr_last;
  logic [ADDR_W-1:0] map_addr, spr_addr;
  logic [DATA_W-1:0] map_data, spr_data;
  logic              map_rdy, spr_rdy;
  logic              frame_lock, clr_err;
  logic              fb_we, busy, oob_err, to_err;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: owner 0 = nobody, 1 = map, 2 = spr; pri = requester that wins a tie.
  int m_owner, m_pri, m_idle, m_addr, m_data;
  bit m_we, m_oob, m_to;

  always #5 clk = ~clk;

  fb_write_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_DEPTH(FB_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .map_req(map_req), .map_addr(map_addr), .map_data(map_data), .map_last(map_last), .map_rdy(map_rdy),
    .spr_req(spr_req), .spr_addr(spr_addr), .spr_data(spr_data), .spr_last(spr_last), .spr_rdy(spr_rdy),
    .frame_lock(frame_lock), .clr_err(clr_err),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .oob_err(oob_err), .to_err(to_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_pri = 1; m_idle = 0;
    m_we = 0; m_addr = 0; m_data = 0; m_oob = 0; m_to = 0;
  endtask

  task automatic model_step();
    int  nxt, req, oreq, addr, data, last;
    bit  oob_set, to_set;
    oob_set = 0; to_set = 0;
    m_we = 0;
    nxt = m_owner;
    if (m_owner == 0) begin
      if (!frame_lock && (map_req || spr_req))
        nxt = (map_req && spr_req) ? m_pri : (map_req ? 1 : 2);
    end else begin
      req  = (m_owner == 1) ? int'(map_req)  : int'(spr_req);
      oreq = (m_owner == 1) ? int'(spr_req)  : int'(map_req);
      addr = (m_owner == 1) ? int'(map_addr) : int'(spr_addr);
      data = (m_owner == 1) ? int'(map_data) : int'(spr_data);
      last = (m_owner == 1) ? int'(map_last) : int'(spr_last);
      if (req != 0) begin
        m_idle = 0;
        if (addr < FB_DEPTH) begin
          m_we = 1; m_addr = addr; m_data = data;
        end else begin
          oob_set = 1;
        end
        if (last != 0) begin
          m_pri = 3 - m_owner;
          nxt = (oreq != 0 && !frame_lock) ? 3 - m_owner : 0;
        end
      end else begin
        m_idle++;
        if (m_idle >= TIMEOUT) begin
          to_set = 1; m_pri = 3 - m_owner; nxt = 0; m_idle = 0;
        end
      end
    end
    m_oob   = oob_set || (m_oob && !clr_err);
    m_to    = to_set  || (m_to  && !clr_err);
    m_owner = nxt;
  endtask

  // Called with inputs already driven, one clock period per call.
  task automatic tick();
    #2;
    check("map_rdy", 32'(map_rdy), 32'(m_owner == 1 && map_req));
    check("spr_rdy", 32'(spr_rdy), 32'(m_owner == 2 && spr_req));
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    check("fb_we",   32'(fb_we),   32'(m_we));
    check("fb_addr", 32'(fb_addr), 32'(m_addr));
    check("fb_data", 32'(fb_data), 32'(m_data));
    check("busy",    32'(busy),    32'(m_owner != 0));
    check("oob_err", 32'(oob_err), 32'(m_oob));
    check("to_err",  32'(to_err),  32'(m_to));
  endtask

  task automatic idle_inputs();
    map_req = 0; map_addr = '0; map_data = '0; map_last = 0;
    spr_req = 0; spr_addr = '0; spr_data = '0; spr_last = 0;
    frame_lock = 0; clr_err = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    tick();
    tick();
    rst_n = 1;
  endtask

  initial begin
    rst_n = 1;
    idle_inputs();
    #1 rst_n = 0;
    model_reset();
    #1;
    check("rst_fb_we",   32'(fb_we),   32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_fb_data", 32'(fb_data), 32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_rdy",     32'({map_rdy, spr_rdy}), 32'd0);
    check("rst_err",     32'({oob_err, to_err}),  32'd0);
    tick();
    rst_n = 1;

    // Both request after reset: map wins, 4-beat burst, then spr with no gap.
    map_req = 1; spr_req = 1; spr_addr = 17'h200; spr_data = 24'h00ABCD;
    tick();
    check("r032_grant", 32'(busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      map_addr = 17'(k); map_data = 24'(24'h110000 + k); map_last = (k == 3);
      tick();
      check("r032_we",   32'(fb_we),   32'd1);
      check("r032_addr", 32'(fb_addr), 32'(k));
    end
    map_req = 0; map_last = 0; spr_last = 1;
    tick();
    check("r032_spr_we",   32'(fb_we),   32'd1);
    check("r032_spr_addr", 32'(fb_addr), 32'h200);
    spr_req = 0; spr_last = 0;
    tick();
    check("r032_idle", 32'(busy), 32'd0);

    // Out-of-range beat is consumed without a write; clear and set-wins.
    do_reset();
    map_req = 1; map_addr = 17'(FB_DEPTH); map_data = 24'h123456;
    tick();
    #1 check("r033_rdy", 32'(map_rdy), 32'd1);
    tick();
    check("r033_we",  32'(fb_we),   32'd0);
    check("r033_oob", 32'(oob_err), 32'd1);
    map_req = 0; clr_err = 1;
    tick();
    check("r033_clr", 32'(oob_err), 32'd0);
    map_req = 1; map_addr = 17'(FB_DEPTH + 1); map_last = 1;
    tick();
    check("r029_setwins", 32'(oob_err), 32'd1);
    clr_err = 0; map_req = 0; map_last = 0;
    tick();

    // frame_lock during an spr burst holds off the map grant.
    do_reset();
    spr_req = 1; spr_addr = 17'h10; spr_data = 24'h0000AA;
    tick();
    frame_lock = 1; map_req = 1; map_addr = 17'h5; map_data = 24'h555555; map_last = 1;
    tick();
    check("r034_spr_beat", 32'(fb_addr), 32'h10);
    spr_addr = 17'h11; spr_last = 1;
    tick();
    check("r034_spr_last", 32'(fb_addr), 32'h11);
    check("r034_locked",   32'(busy),    32'd0);
    spr_req = 0; spr_last = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("r034_hold", 32'(busy), 32'd0);
    end
    frame_lock = 0;
    tick();
    check("r034_grant", 32'(busy), 32'd1);
    tick();
    check("r034_map_we",   32'(fb_we),   32'd1);
    check("r034_map_addr", 32'(fb_addr), 32'h5);
    map_req = 0; map_last = 0;
    tick();

    // Stalled spr burst times out after TIMEOUT idle cycles.
    do_reset();
    spr_req = 1;
    tick();
    spr_req = 0;
    for (int k = 0; k < TIMEOUT - 1; k++) tick();
    check("r035_before_busy", 32'(busy),   32'd1);
    check("r035_before_to",   32'(to_err), 32'd0);
    tick();
    check("r035_busy", 32'(busy),   32'd0);
    check("r035_to",   32'(to_err), 32'd1);

    // Reset in the middle of a burst drops it.
    do_reset();
    map_req = 1; map_addr = 17'hFE;
    tick();
    tick();
    map_addr = 17'hFF;
    tick();
    map_addr = 17'h100;
    rst_n = 0;
    #1;
    check("r036_we",   32'(fb_we),   32'd0);
    check("r036_busy", 32'(busy),    32'd0);
    check("r036_rdy",  32'(map_rdy), 32'd0);
    model_reset();
    tick();
    map_addr = 17'h101;
    rst_n = 1;
    tick();
    check("r036_nowrite", 32'(fb_we), 32'd0);
    map_req = 0;
    tick();
    check("r036_nowrite2", 32'(fb_we), 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      map_req    = ($urandom_range(0, 3) != 0);
      spr_req    = ($urandom_range(0, 3) != 0);
      map_addr   = ($urandom_range(0, 15) == 0) ? 17'(FB_DEPTH + $urandom_range(0, 99))
                                                : 17'($urandom_range(0, FB_DEPTH - 1));
      spr_addr   = ($urandom_range(0, 15) == 0) ? 17'(FB_DEPTH + $urandom_range(0, 99))
                                                : 17'($urandom_range(0, FB_DEPTH - 1));
      map_data   = 24'($urandom);
      spr_data   = 24'($urandom);
      map_last   = ($urandom_range(0, 3) == 0);
      spr_last   = ($urandom_range(0, 3) == 0);
      frame_lock = ($urandom_range(0, 9) == 0);
      clr_err    = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, frame-buffer address width.
REQ-002 SHALL have parameter DATA_W, default 24, pixel width (RGB 8:8:8).
REQ-003 SHALL have parameter FB_DEPTH, default 76800, number of valid frame-buffer words (320x240).
REQ-004 SHALL have parameter TIMEOUT, default 255, max idle cycles inside a granted burst (8-bit count).
REQ-005 SHALL have ports: clk  in  1  sole clock (100 MHz domain); all logic on rising edge.
REQ-006 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: map_req / spr_req  in  1  requester has a write beat valid.
REQ-008 SHALL have ports: map_addr / spr_addr  in  ADDR_W  beat address.
REQ-009 SHALL have ports: map_data / spr_data  in  DATA_W  beat pixel data.
REQ-010 SHALL have ports: map_last / spr_last  in  1  beat is final beat of burst.
REQ-011 SHALL have ports: map_rdy / spr_rdy  out  1  beat accepted this cycle.
REQ-012 SHALL have ports: frame_lock  in  1  inhibit new burst grants.
REQ-013 SHALL have ports: clr_err  in  1  clear sticky error flags.
REQ-014 SHALL have ports: fb_we  out  1, fb_addr  out  ADDR_W, fb_data  out  DATA_W  frame-buffer port A write.
REQ-015 SHALL have ports: busy  out  1  a burst is granted.
REQ-016 SHALL have ports: oob_err / to_err  out  1  sticky out-of-range / timeout flags.

Function
REQ-017 SHALL implement FSM states IDLE, GNT_MAP, GNT_SPR.
REQ-018 IDLE: if frame_lock=0 and any req, SHALL enter GNT of requester; both requesting -> requester not served last (rr pointer).
REQ-019 SHALL not grant in the cycle a request is first seen in IDLE; first beat accepted in the cycle after (grant latency 1).
REQ-020 In GNT_x, x_rdy SHALL equal x_req combinationally; other requester's rdy SHALL be 0.
REQ-021 Beat accepted (req&rdy) at cycle N SHALL appear on fb_we/fb_addr/fb_data at cycle N+1 (registered); fb_we=0 when no beat accepted.
REQ-022 fb_addr/fb_data SHALL hold last value when fb_we=0.
REQ-023 Accepted beat with addr >= FB_DEPTH SHALL be consumed (rdy=1) but fb_we SHALL stay 0; oob_err SHALL set next cycle.
REQ-024 Accepted beat with last=1 SHALL end burst; rr pointer SHALL point to the other requester.
REQ-025 On burst end, if other requester's req=1 and frame_lock=0, SHALL go directly to its GNT state (no IDLE bubble); else IDLE.
REQ-026 frame_lock asserted mid-burst SHALL not interrupt the burst; only gates new grants.
REQ-027 In GNT_x, idle counter SHALL increment each cycle x_req=0, clear on accepted beat; reaching TIMEOUT SHALL release to IDLE, set to_err, and flip rr pointer.
REQ-028 busy SHALL be 1 in GNT_MAP/GNT_SPR, 0 in IDLE.
REQ-029 oob_err/to_err SHALL clear on clr_err=1; simultaneous set and clear -> set wins.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, rr pointer=map, idle counter=0, fb_we=0, fb_addr=0, fb_data=0, errors=0, all rdy=0, busy=0.
REQ-031 Reset mid-burst SHALL discard the burst; no partial write issued after reset deasserts.

Verification
REQ-032 Both req=1 first cycle after reset -> map granted; map burst of 4 (addr 0..3, last on 4th) -> fb_we=1 four consecutive cycles, then spr granted with no gap.
REQ-033 map_addr=76800 in GNT_MAP -> map_rdy=1, fb_we=0, oob_err=1 next cycle; clr_err=1 -> oob_err=0.
REQ-034 frame_lock=1 during spr burst, map_req=1 -> spr burst completes; map not granted until frame_lock=0.
REQ-035 GNT_SPR with spr_req=0 for 255 cycles -> state IDLE, to_err=1, busy=0.
REQ-036 rst_n pulsed low mid-burst at addr 0x100 -> fb_we=0, busy=0 immediately; no write at 0x101 after release.
